// File: rtl/cipher_block_fifo.sv
// ---------------------------------------------------------------------------
// cipher_block_fifo
//
// First-word-fall-through FIFO for ciphertext blocks. When a block is written
// as the last block of a message, it can be truncated: only the leading
// (most-significant, big-endian) nbytes_i bytes are kept and the rest are
// stored as zero. A write into a full FIFO with no pop is dropped and raises
// a sticky overflow flag.
//
// Parameters
//   DATA_W  block width in bits (multiple of 8, >= 8)
//   DEPTH   number of stored blocks (power of 2, >= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous reset, active low
//   en_cipher   write strobe
//   cipher_i    block to write
//   last_i      block is the final block of a message
//   nbytes_i    valid bytes in a last block (0 = all bytes valid)
//   ready_i     consumer accepts the head block
//   clr_err_i   clears the sticky overflow flag
//   valid_o     head block available (FIFO not empty)
//   cipher_o    head block, already masked (0 when empty)
//   last_o      last flag of the head block (0 when empty)
//   count_o     number of stored blocks
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
//   overflow_o  sticky: a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module cipher_block_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en_cipher,
    input  logic [DATA_W-1:0]             cipher_i,
    input  logic                          last_i,
    input  logic [$clog2(DATA_W/8+1)-1:0] nbytes_i,
    input  logic                          ready_i,
    input  logic                          clr_err_i,
    output logic                          valid_o,
    output logic [DATA_W-1:0]             cipher_o,
    output logic                          last_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o
);

    localparam int NB  = DATA_W / 8;
    localparam int NBW = $clog2(NB + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    // Storage word is {last, data}; the array is never reset because the
    // head register below never exposes an entry that was not written.
    logic [DATA_W:0] mem [DEPTH];

    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic [DATA_W:0] head_reg;

    logic [DATA_W-1:0] masked;
    logic [DATA_W:0]   wr_word;
    logic              trunc;
    logic              pop;
    logic              push;
    logic              overflow_event;
    logic              bypass;

    // -----------------------------------------------------------------------
    // Byte masking of a partial last block. Byte gi is counted from the MSB
    // end, so byte gi survives when gi < nbytes_i.
    // -----------------------------------------------------------------------
    assign trunc = last_i && (nbytes_i != '0) && (nbytes_i < NBW'(NB));

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign masked[DATA_W-1-8*gi -: 8] =
                (!trunc || (NBW'(gi) < nbytes_i)) ? cipher_i[DATA_W-1-8*gi -: 8] : 8'h00;
        end
    endgenerate

    assign wr_word = {last_i, masked};

    // -----------------------------------------------------------------------
    // Handshake. A pop frees a slot on the same edge, so a full FIFO still
    // accepts a write when the consumer takes the head.
    // -----------------------------------------------------------------------
    assign pop            = !empty_o && ready_i;
    assign push           = en_cipher && (!full_o || pop);
    assign overflow_event = en_cipher && full_o && !pop;

    always_comb begin
        rd_ptr_next   = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        wr_ptr_next   = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;

        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end

        // A new overflow takes priority over a clear on the same edge.
        overflow_next = overflow_reg;
        if (overflow_event) begin
            overflow_next = 1'b1;
        end else if (clr_err_i) begin
            overflow_next = 1'b0;
        end
    end

    // The incoming block becomes the next head exactly when it is written to
    // the slot the read pointer is about to point at (empty FIFO, or the only
    // stored block is being popped). In that case the array still holds the
    // stale value, so the head register takes the write data directly.
    assign bypass = push && (wr_ptr_reg == rd_ptr_next);

    // -----------------------------------------------------------------------
    // Control state and registered head (registered read of the array).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            head_reg     <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            if (count_next == '0) begin
                head_reg <= '0;
            end else if (bypass) begin
                head_reg <= wr_word;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    // Storage write port; writes are suppressed while reset is asserted so a
    // push on a reset edge leaves no trace.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cipher_o   = head_reg[DATA_W-1:0];
    assign last_o     = head_reg[DATA_W];
    assign count_o    = count_reg;
    assign full_o     = (count_reg == CW'(DEPTH));
    assign empty_o    = (count_reg == '0);
    assign valid_o    = !empty_o;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_cipher_block_fifo.sv
// ---------------------------------------------------------------------------
// tb_cipher_block_fifo
//
// Three instances of cipher_block_fifo (64x4, 128x2, 32x8) share one set of
// input stimulus; one configuration is exercised at a time and its outputs
// are compared every cycle against a queue-based reference model. Directed
// sequences (basic path, masking, fill/overflow, full push+pop, reset
// mid-stream) are followed by a randomized phase per configuration.
// ---------------------------------------------------------------------------
module tb_cipher_block_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic         rst_n;
    logic         en;
    logic         last;
    logic         rdy;
    logic         clr;
    logic [127:0] din;
    logic [4:0]   nb;

    // Configuration 0: DATA_W=64, DEPTH=4
    logic        v0, l0, f0, e0, o0;
    logic [63:0] c0;
    logic [2:0]  n0;
    // Configuration 1: DATA_W=128, DEPTH=2
    logic         v1, l1, f1, e1, o1;
    logic [127:0] c1;
    logic [1:0]   n1;
    // Configuration 2: DATA_W=32, DEPTH=8
    logic        v2, l2, f2, e2, o2;
    logic [31:0] c2;
    logic [3:0]  n2;

    cipher_block_fifo #(.DATA_W(64), .DEPTH(4)) dut0 (
        .clk(clk), .reset(rst_n), .en_cipher(en), .cipher_i(din[63:0]),
        .last_i(last), .nbytes_i(nb[3:0]), .ready_i(rdy), .clr_err_i(clr),
        .valid_o(v0), .cipher_o(c0), .last_o(l0), .count_o(n0),
        .full_o(f0), .empty_o(e0), .overflow_o(o0)
    );

    cipher_block_fifo #(.DATA_W(128), .DEPTH(2)) dut1 (
        .clk(clk), .reset(rst_n), .en_cipher(en), .cipher_i(din),
        .last_i(last), .nbytes_i(nb), .ready_i(rdy), .clr_err_i(clr),
        .valid_o(v1), .cipher_o(c1), .last_o(l1), .count_o(n1),
        .full_o(f1), .empty_o(e1), .overflow_o(o1)
    );

    cipher_block_fifo #(.DATA_W(32), .DEPTH(8)) dut2 (
        .clk(clk), .reset(rst_n), .en_cipher(en), .cipher_i(din[31:0]),
        .last_i(last), .nbytes_i(nb[2:0]), .ready_i(rdy), .clr_err_i(clr),
        .valid_o(v2), .cipher_o(c2), .last_o(l2), .count_o(n2),
        .full_o(f2), .empty_o(e2), .overflow_o(o2)
    );

    // Outputs of the configuration under test
    int           cur = 0;
    logic         obs_v, obs_l, obs_f, obs_e, obs_o;
    logic [127:0] obs_c;
    logic [3:0]   obs_cnt;

    always_comb begin
        obs_v   = 1'b0;
        obs_l   = 1'b0;
        obs_f   = 1'b0;
        obs_e   = 1'b0;
        obs_o   = 1'b0;
        obs_c   = '0;
        obs_cnt = '0;
        case (cur)
            0: begin
                obs_v = v0; obs_l = l0; obs_f = f0; obs_e = e0; obs_o = o0;
                obs_c = 128'(c0); obs_cnt = 4'(n0);
            end
            1: begin
                obs_v = v1; obs_l = l1; obs_f = f1; obs_e = e1; obs_o = o1;
                obs_c = c1; obs_cnt = 4'(n1);
            end
            default: begin
                obs_v = v2; obs_l = l2; obs_f = f2; obs_e = e2; obs_o = o2;
                obs_c = 128'(c2); obs_cnt = n2;
            end
        endcase
    end

    // Reference model state
    logic [127:0] q_data[$];
    logic         q_last[$];
    logic         m_ovf = 1'b0;
    int           dw = 64;
    int           dp = 4;
    int           nbw = 4;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s got %0h expected %0h", cur, tag, got, exp);
        end
    endtask

    // Block as stored: truncated to dw bits, and for a partial last block
    // only the top n bytes kept.
    function automatic logic [127:0] mask_blk(input logic [127:0] d, input logic l, input int n);
        logic [127:0] m;
        m = (128'd1 << dw) - 128'd1;
        if (l && n != 0 && n < dw / 8) begin
            m = m & ~(m >> (8 * n));
        end
        return d & m;
    endfunction

    task automatic compare();
        int n;
        n = q_data.size();
        check("count", 128'(obs_cnt), 128'(n));
        check("valid", 128'(obs_v), 128'(n > 0));
        check("empty", 128'(obs_e), 128'(n == 0));
        check("full", 128'(obs_f), 128'(n == dp));
        check("overflow", 128'(obs_o), 128'(m_ovf));
        check("data", obs_c, (n > 0) ? q_data[0] : 128'd0);
        check("last", 128'(obs_l), (n > 0) ? 128'(q_last[0]) : 128'd0);
    endtask

    // One clock: apply the model to the inputs present at the edge, then
    // compare the DUT a little after the edge.
    task automatic step();
        logic pop_m, push_m, ovf_m;
        @(posedge clk);
        if (!rst_n) begin
            q_data.delete();
            q_last.delete();
            m_ovf = 1'b0;
        end else begin
            pop_m  = (q_data.size() > 0) && rdy;
            push_m = en && ((q_data.size() < dp) || pop_m);
            ovf_m  = en && (q_data.size() == dp) && !pop_m;
            if (pop_m) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            if (push_m) begin
                q_data.push_back(mask_blk(din, last, int'(nb)));
                q_last.push_back(last);
            end
            if (ovf_m) begin
                m_ovf = 1'b1;
            end else if (clr) begin
                m_ovf = 1'b0;
            end
        end
        #1;
        compare();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_cfg(input int c);
        int keep;
        int rdy_bias;
        cur = c;
        dw  = (c == 0) ? 64 : (c == 1) ? 128 : 32;
        dp  = (c == 0) ? 4  : (c == 1) ? 2   : 8;
        nbw = (c == 0) ? 4  : (c == 1) ? 5   : 3;

        // Reset with every other control asserted
        rst_n = 1'b0; en = 1'b1; rdy = 1'b1; clr = 1'b1; last = 1'b1; nb = '0; din = '1;
        step();
        step();
        rst_n = 1'b1; en = 1'b0; rdy = 1'b0; clr = 1'b0; last = 1'b0;
        step();

        // Basic path
        din = {2{64'h0123456789ABCDEF}};
        en  = 1'b1;
        step();
        en  = 1'b0;
        check("basic_count", 128'(obs_cnt), 128'd1);
        if (c == 0) check("basic_data", obs_c, 128'h0123456789ABCDEF);
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("basic_empty", 128'(obs_e), 128'd1);

        // Masking of last blocks
        din = '1; last = 1'b1; nb = 5'd3; en = 1'b1;
        step();
        if (c == 0) check("mask3_data", obs_c, 128'hFFFFFF0000000000);
        check("mask3_last", 128'(obs_l), 128'd1);
        nb  = 5'd0; rdy = 1'b1;
        step();
        if (c == 0) check("mask0_data", obs_c, 128'hFFFFFFFFFFFFFFFF);
        nb = 5'(dw / 8);
        step();
        nb = 5'((1 << nbw) - 1);
        step();
        en = 1'b0; last = 1'b0; nb = '0;
        step();
        rdy = 1'b0;

        // Fill, overflow, clear
        en = 1'b1;
        for (int i = 0; i < dp; i++) begin
            din = rnd128();
            step();
        end
        check("fill_full", 128'(obs_f), 128'd1);
        din = rnd128();
        step();
        check("ovf_set", 128'(obs_o), 128'd1);
        en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovf_clr", 128'(obs_o), 128'd0);

        // Push and pop while full: pointers wrap twice
        en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 2 * dp; i++) begin
            din  = rnd128();
            last = 1'($urandom_range(0, 1));
            step();
        end
        last = 1'b0;
        check("full_pp_count", 128'(obs_cnt), 128'(dp));

        // New overflow on the same edge as a clear: overflow wins
        rdy = 1'b0; clr = 1'b1; din = rnd128();
        step();
        check("ovf_vs_clr", 128'(obs_o), 128'd1);
        en = 1'b0;
        step();
        clr = 1'b0;

        // Reset mid-stream with a push requested
        keep = (dp < 3) ? dp : 3;
        rdy  = 1'b1;
        while (q_data.size() > keep) step();
        rdy   = 1'b0;
        rst_n = 1'b0; en = 1'b1; din = rnd128();
        step();
        check("rst_count", 128'(obs_cnt), 128'd0);
        check("rst_data", obs_c, 128'd0);
        rst_n = 1'b1; en = 1'b0;
        step();

        // Randomized traffic with varying consumer pressure
        rdy_bias = 50;
        for (int k = 0; k < 400; k++) begin
            if (k % 40 == 0) rdy_bias = int'($urandom_range(10, 90));
            rst_n = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 99) < 60);
            rdy   = ($urandom_range(0, 99) < rdy_bias);
            clr   = ($urandom_range(0, 15) == 0);
            last  = 1'($urandom_range(0, 1));
            nb    = 5'($urandom_range(0, (1 << nbw) - 1));
            din   = rnd128();
            step();
        end
        rst_n = 1'b1; en = 1'b0; rdy = 1'b0; clr = 1'b0; last = 1'b0; nb = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        last  = 1'b0;
        rdy   = 1'b0;
        clr   = 1'b0;
        din   = '0;
        nb    = '0;
        for (int c = 0; c < 3; c++) begin
            run_cfg(c);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
